pwl_act_stream: RTL and testbench
=================================

Name: pwl_act_stream

Overview:
- Streaming piecewise-linear (NN-LUT style) activation unit; successor to the fixed-table per-row GELU array.
- Processes LANES signed elements per beat under valid/ready flow control.
- Runtime-programmable breakpoint/slope/bias tables, NUM_BANKS banks selectable per beat (e.g. GELU, SiLU).
- Sits between the matmul output stream and requantisation in the FFN datapath.

Parameters:
- LANES, 16, elements per beat.
- X_WIDTH, 8, signed input element width.
- K_WIDTH, 16, signed slope width (fixed point, FRAC_SHIFT fraction bits).
- B_WIDTH, 24, signed bias width (same scale as k*x).
- BP_NUM, 16, segments per bank.
- NUM_BANKS, 2, independent tables.
- FRAC_SHIFT, 8, right shift applied to k*x+b.
- OUT_WIDTH, 8, signed output element width.

Ports:
- clk_p  in  1  clock.
- rst_p  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&in_ready.
- in_data  in  LANES*X_WIDTH  lane i at bits [(i+1)*X_WIDTH-1 : i*X_WIDTH].
- in_bank  in  clog2(NUM_BANKS)  table bank for this beat.
- in_last  in  1  row-end marker, passed through.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*OUT_WIDTH  results, same lane packing.
- out_last  out  1  delayed in_last.
- cfg_we  in  1  table write strobe.
- cfg_bank  in  clog2(NUM_BANKS)  write bank.
- cfg_addr  in  clog2(BP_NUM)  segment index.
- cfg_bp  in  X_WIDTH  signed lower bound of segment cfg_addr (ignored for addr 0).
- cfg_k  in  K_WIDTH  slope.
- cfg_b  in  B_WIDTH  bias.
- sat_flag  out  1  sticky: any lane saturated since reset or sat_clr.
- sat_clr  in  1  clears sat_flag.

Behaviour:
- Reset (rst_p=1 at clk_p edge): all pipeline valids 0, out_valid 0, out_data 0, out_last 0, sat_flag 0; all table k, b, bp = 0, so every output is 0 until programmed. Reset mid-stream drops all in-flight beats; no partial output.
- Pipeline, 3 stages, latency 3 cycles from accept to out_valid with out_ready held 1; throughput 1 beat/cycle.
- S1: per lane, seg = largest j in 1..BP_NUM-1 with x >= bp[bank][j], else 0. Latch x, k[bank][seg], b[bank][seg], last, valid.
- S2: prod = k*x, signed, K_WIDTH+X_WIDTH bits.
- S3: sum = prod + sign-extended b at RES_W = max(K_WIDTH+X_WIDTH, B_WIDTH)+1; r = (sum + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (round half up). Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; register to out_data.
- Breakpoints must be programmed strictly ascending in j; non-monotonic tables still give the largest-j rule, no error.
- Flow control: stall = out_valid & ~out_ready. On stall, all stages hold; in_ready = ~stall. Bubbles are not compressed. out_data/out_last stable while out_valid & ~out_ready.
- Config writes take effect at the clk_p edge where cfg_we=1. A beat in S1 in that cycle uses the pre-write values. Beats past S1 are unaffected (k, b already latched). Writes are legal at any time, including during a stall.
- sat_flag is set when an S3 result saturates on a cycle where S3 advances. If sat_clr and a new saturation coincide, set wins.
- in_bank >= NUM_BANKS: treated as bank 0.

Decomposition:
- Shared package pwl_act_pkg: RES_W computation function, bank/addr index width constants, the saturate-and-round function.
- One sub-module: pwl_lane (S1 segment compare through S3 saturate for one element); top instantiates LANES copies and holds the tables, valid/ready pipeline control and sat_flag.

Test Plan:
- Reset -> out_valid=0, sat_flag=0. Unprogrammed table, in_data lanes = 37 -> out_data all 0 three cycles after accept.
- Bank0, all segments k=256, b=0 (identity); x=37, -5, 127 -> 37, -5, 127 at latency 3. Back-to-back 8 beats -> 8 consecutive out_valid cycles, out_last on beat 8 only.
- Rounding: k=128, b=0; x=3 -> 2, x=-3 -> -1, x=1 -> 1.
- Segments: bank1 bp[1]=0, seg0 k=0 b=0, seg1 k=256 b=0 (ReLU); x=-1 -> 0, x=0 -> 0, x=5 -> 5. Same beat stream alternating in_bank 0/1 routes each beat to the correct table.
- Saturation: k=1024; x=100 -> 127, x=-100 -> -128, sat_flag=1. Assert sat_clr -> sat_flag=0 next cycle.
- Backpressure and reset: 3 beats in flight, out_ready=0 for 5 cycles -> in_ready=0, out_data held, no loss or duplication after release. rst_p pulsed with beats in flight -> out_valid=0 next cycle and no stale beat emitted afterwards.

Source files
------------

// File: rtl/pwl_act_stream_pkg.sv
// Shared helpers for the piecewise-linear activation stream: index widths,
// accumulator sizing, and the round-half-up / saturate step at the output.
package pwl_act_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One guard bit above the wider of k*x and b so the sum cannot overflow.
  function automatic int res_w(input int kw, input int xw, input int bw);
    return ((kw + xw > bw) ? kw + xw : bw) + 1;
  endfunction

  localparam int BANK_W_DEF = idx_w(2);
  localparam int ADDR_W_DEF = idx_w(16);

  function automatic logic signed [63:0] rnd_shift(input logic signed [63:0] sum, input int frac);
    return (sum + (64'sd1 <<< (frac - 1))) >>> frac;
  endfunction

  function automatic logic signed [63:0] out_max(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] sum, input int frac, input int ow);
    logic signed [63:0] r;
    r = rnd_shift(sum, frac);
    return (r > out_max(ow)) || (r < -out_max(ow) - 64'sd1);
  endfunction

  function automatic logic signed [63:0] sat_round(input logic signed [63:0] sum, input int frac, input int ow);
    logic signed [63:0] r;
    r = rnd_shift(sum, frac);
    if (r > out_max(ow))
      return out_max(ow);
    else if (r < -out_max(ow) - 64'sd1)
      return -out_max(ow) - 64'sd1;
    else
      return r;
  endfunction

endpackage

// File: rtl/pwl_act_stream_lane.sv
// One element of the PWL activation: segment select, multiply, bias/round/saturate.
// Three register stages; each advances only on its enable, so the top freezes it on stall.
module pwl_lane
  import pwl_act_pkg::*;
#(
  parameter int X_WIDTH    = 8,
  parameter int K_WIDTH    = 16,
  parameter int B_WIDTH    = 24,
  parameter int BP_NUM     = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                              clk_p,
  input  logic                              rst_p,
  input  logic                              en_s1,
  input  logic                              en_s2,
  input  logic                              en_s3,
  input  logic signed [X_WIDTH-1:0]         x,
  input  logic [(BP_NUM-1)*X_WIDTH-1:0]     bp_row,
  input  logic [BP_NUM*K_WIDTH-1:0]         k_row,
  input  logic [BP_NUM*B_WIDTH-1:0]         b_row,
  output logic signed [OUT_WIDTH-1:0]       y,
  output logic                              sat
);
  localparam int PW    = K_WIDTH + X_WIDTH;
  localparam int RES_W = res_w(K_WIDTH, X_WIDTH, B_WIDTH);

  logic signed [K_WIDTH-1:0] k_sel, k1;
  logic signed [B_WIDTH-1:0] b_sel, b1, b2;
  logic signed [X_WIDTH-1:0] x1;
  logic signed [PW-1:0]      prod2;
  logic signed [RES_W-1:0]   sum;

  // bp_row holds entries 1..BP_NUM-1; the highest matching segment wins.
  always_comb begin
    k_sel = k_row[K_WIDTH-1:0];
    b_sel = b_row[B_WIDTH-1:0];
    for (int j = 1; j < BP_NUM; j++) begin
      if (x >= $signed(bp_row[(j-1)*X_WIDTH +: X_WIDTH])) begin
        k_sel = k_row[j*K_WIDTH +: K_WIDTH];
        b_sel = b_row[j*B_WIDTH +: B_WIDTH];
      end
    end
  end

  always_comb begin
    sum = RES_W'(prod2) + RES_W'(b2);
    sat = sat_hit(64'(sum), FRAC_SHIFT, OUT_WIDTH);
  end

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      x1    <= '0;
      k1    <= '0;
      b1    <= '0;
      prod2 <= '0;
      b2    <= '0;
      y     <= '0;
    end else begin
      if (en_s1) begin
        x1 <= x;
        k1 <= k_sel;
        b1 <= b_sel;
      end
      if (en_s2) begin
        prod2 <= PW'(x1) * PW'(k1);
        b2    <= b1;
      end
      if (en_s3)
        y <= OUT_WIDTH'(sat_round(64'(sum), FRAC_SHIFT, OUT_WIDTH));
    end
  end

endmodule

// File: rtl/pwl_act_stream.sv
// Streaming PWL activation over LANES elements with banked programmable tables; 3-cycle latency.
// Full stall when out_valid & ~out_ready: every stage holds and in_ready drops.
module pwl_act_stream
  import pwl_act_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int X_WIDTH    = 8,
  parameter int K_WIDTH    = 16,
  parameter int B_WIDTH    = 24,
  parameter int BP_NUM     = 16,
  parameter int NUM_BANKS  = 2,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                             clk_p,
  input  logic                             rst_p,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*X_WIDTH-1:0]         in_data,
  input  logic [idx_w(NUM_BANKS)-1:0]      in_bank,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*OUT_WIDTH-1:0]       out_data,
  output logic                             out_last,
  input  logic                             cfg_we,
  input  logic [idx_w(NUM_BANKS)-1:0]      cfg_bank,
  input  logic [idx_w(BP_NUM)-1:0]         cfg_addr,
  input  logic [X_WIDTH-1:0]               cfg_bp,
  input  logic [K_WIDTH-1:0]               cfg_k,
  input  logic [B_WIDTH-1:0]               cfg_b,
  output logic                             sat_flag,
  input  logic                             sat_clr
);
  localparam int BANK_W = idx_w(NUM_BANKS);

  logic [X_WIDTH-1:0] bp_tab [NUM_BANKS][BP_NUM];
  logic [K_WIDTH-1:0] k_tab  [NUM_BANKS][BP_NUM];
  logic [B_WIDTH-1:0] b_tab  [NUM_BANKS][BP_NUM];

  logic [BANK_W-1:0]               sel_bank;
  logic [(BP_NUM-1)*X_WIDTH-1:0]   bp_row;
  logic [BP_NUM*K_WIDTH-1:0]       k_row;
  logic [BP_NUM*B_WIDTH-1:0]       b_row;
  logic [LANES-1:0]                lane_sat;
  logic stall, acc, s1_vld, s2_vld, s1_last, s2_last;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign acc      = in_valid & ~stall;

  // Out-of-range bank selects fall back to bank 0.
  always_comb begin
    sel_bank = (32'(in_bank) < NUM_BANKS) ? in_bank : '0;
    bp_row   = '0;
    k_row    = '0;
    b_row    = '0;
    for (int j = 0; j < BP_NUM; j++) begin
      k_row[j*K_WIDTH +: K_WIDTH] = k_tab[sel_bank][j];
      b_row[j*B_WIDTH +: B_WIDTH] = b_tab[sel_bank][j];
      if (j > 0)
        bp_row[(j-1)*X_WIDTH +: X_WIDTH] = bp_tab[sel_bank][j];
    end
  end

  // S1 reads the tables combinationally, so a same-cycle write lands after that beat.
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        for (int j = 0; j < BP_NUM; j++) begin
          bp_tab[i][j] <= '0;
          k_tab[i][j]  <= '0;
          b_tab[i][j]  <= '0;
        end
      end
    end else if (cfg_we && (32'(cfg_bank) < NUM_BANKS) && (32'(cfg_addr) < BP_NUM)) begin
      bp_tab[cfg_bank][cfg_addr] <= cfg_bp;
      k_tab[cfg_bank][cfg_addr]  <= cfg_k;
      b_tab[cfg_bank][cfg_addr]  <= cfg_b;
    end
  end

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      s1_last   <= 1'b0;
      s2_last   <= 1'b0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      if (!stall) begin
        s1_vld    <= acc;
        s2_vld    <= s1_vld;
        out_valid <= s2_vld;
        if (acc)    s1_last  <= in_last;
        if (s1_vld) s2_last  <= s1_last;
        if (s2_vld) out_last <= s2_last;
      end
      if (!stall && s2_vld && (|lane_sat))
        sat_flag <= 1'b1;
      else if (sat_clr)
        sat_flag <= 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pwl_lane #(
      .X_WIDTH(X_WIDTH), .K_WIDTH(K_WIDTH), .B_WIDTH(B_WIDTH),
      .BP_NUM(BP_NUM), .FRAC_SHIFT(FRAC_SHIFT), .OUT_WIDTH(OUT_WIDTH)
    ) u_lane (
      .clk_p  (clk_p),
      .rst_p  (rst_p),
      .en_s1  (acc),
      .en_s2  (~stall & s1_vld),
      .en_s3  (~stall & s2_vld),
      .x      (in_data[i*X_WIDTH +: X_WIDTH]),
      .bp_row (bp_row),
      .k_row  (k_row),
      .b_row  (b_row),
      .y      (out_data[i*OUT_WIDTH +: OUT_WIDTH]),
      .sat    (lane_sat[i])
    );
  end

endmodule

// File: tb/tb_pwl_act_stream.sv
// Directed scoreboard bench for pwl_act_stream: expected beats queued at drive time,
// compared in a negedge monitor on every output handshake.
module tb_pwl_act_stream;
  logic         clk_p = 1'b0;
  logic         rst_p, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic         cfg_we, sat_flag, sat_clr;
  logic [127:0] in_data, out_data;
  logic [0:0]   in_bank, cfg_bank;
  logic [3:0]   cfg_addr;
  logic [7:0]   cfg_bp;
  logic [15:0]  cfg_k;
  logic [23:0]  cfg_b;

  always #5 clk_p = ~clk_p;

  pwl_act_stream dut (
    .clk_p(clk_p), .rst_p(rst_p),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bank(in_bank), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .cfg_we(cfg_we), .cfg_bank(cfg_bank), .cfg_addr(cfg_addr), .cfg_bp(cfg_bp), .cfg_k(cfg_k), .cfg_b(cfg_b),
    .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  typedef struct packed {
    logic [127:0] d;
    logic         l;
  } exp_t;

  exp_t exp_q[$];
  int   m_bp [2][16];
  int   m_k  [2][16];
  int   m_b  [2][16];
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   max_run = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: largest matching segment, k*x+b, round half up, clip to int8.
  function automatic logic [127:0] model(input logic [127:0] d, input int bank);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      logic signed [7:0] x;
      int     seg;
      longint s, q;
      x   = d[i*8 +: 8];
      seg = 0;
      for (int j = 1; j < 16; j++)
        if (int'(x) >= m_bp[bank][j]) seg = j;
      s = longint'(m_k[bank][seg]) * longint'(x) + longint'(m_b[bank][seg]);
      q = (s + 128) >>> 8;
      if (q > 127) q = 127;
      else if (q < -128) q = -128;
      r[i*8 +: 8] = q[7:0];
    end
    return r;
  endfunction

  task automatic cfg(input int bank, input int addr, input int bp, input int k, input int b);
    cfg_we   = 1'b1;
    cfg_bank = 1'(bank);
    cfg_addr = 4'(addr);
    cfg_bp   = 8'(bp);
    cfg_k    = 16'(k);
    cfg_b    = 24'(b);
    @(posedge clk_p); #1;
    cfg_we = 1'b0;
    m_bp[bank][addr] = bp;
    m_k[bank][addr]  = k;
    m_b[bank][addr]  = b;
  endtask

  task automatic fill_bank(input int bank, input int k, input int b);
    for (int a = 0; a < 16; a++) cfg(bank, a, 0, k, b);
  endtask

  task automatic send(input int base, input int step, input int bank, input logic last);
    logic [127:0] d;
    exp_t e;
    int   n;
    logic ok;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(base + i * step);
    in_data  = d;
    in_bank  = 1'(bank);
    in_last  = last;
    in_valid = 1'b1;
    e.d = model(d, bank);
    e.l = last;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk_p);
      ok = in_ready;
      @(posedge clk_p); #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) check("accept_timeout", in_ready, 1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_p);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk_p); #1;
  endtask

  always @(negedge clk_p) begin
    if (rst_p !== 1'b0 || out_valid !== 1'b1 || out_ready !== 1'b1) begin
      if (out_valid !== 1'b1) run_len = 0;
    end else begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", out_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("beat_data", out_data, e.d);
        check("beat_last", out_last, e.l);
      end
    end
  end

  initial begin
    logic [127:0] hold;
    int n;
    rst_p = 1'b1; in_valid = 1'b0; in_data = '0; in_bank = '0; in_last = 1'b0;
    out_ready = 1'b1; cfg_we = 1'b0; cfg_bank = '0; cfg_addr = '0;
    cfg_bp = '0; cfg_k = '0; cfg_b = '0; sat_clr = 1'b0;

    repeat (3) @(posedge clk_p);
    @(negedge clk_p);
    check("rst_out_valid", out_valid, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk_p); #1;
    rst_p = 1'b0;

    // Unprogrammed tables give zero; also measures accept-to-valid latency.
    send(37, 0, 0, 1'b0);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk_p);
      n++;
    end while (out_valid !== 1'b1 && n < 10);
    check("latency", n, 3);
    check("unprog_zero", out_data, 0);
    drain();

    fill_bank(0, 256, 0);
    send(37, 0, 0, 1'b0);
    send(-5, 0, 0, 1'b0);
    send(127, 0, 0, 1'b0);
    send(-5, 9, 0, 1'b0);
    drain();

    max_run = 0;
    for (int i = 0; i < 8; i++) send(i * 11 - 40, 3, 0, i == 7);
    drain();
    check("b2b_run", max_run, 8);

    cfg(1, 0, 0, 0, 0);
    for (int a = 1; a < 16; a++) cfg(1, a, (a == 1) ? 0 : a * 8, 256, 0);
    send(-1, 0, 1, 1'b0);
    send(0, 0, 1, 1'b0);
    send(5, 0, 1, 1'b0);
    for (int i = 0; i < 6; i++) send(-5, 3, i % 2, 1'b0);
    drain();
    check("sat_flag_idle", sat_flag, 0);

    fill_bank(0, 128, 0);
    send(3, 0, 0, 1'b0);
    send(-3, 0, 0, 1'b0);
    send(1, 0, 0, 1'b0);
    drain();

    fill_bank(0, 1024, 0);
    send(100, 0, 0, 1'b0);
    send(-100, 0, 0, 1'b1);
    drain();
    check("sat_flag_set", sat_flag, 1);
    sat_clr = 1'b1;
    @(posedge clk_p); #1;
    sat_clr = 1'b0;
    check("sat_flag_cleared", sat_flag, 0);

    // Backpressure: three beats pile up behind a blocked output.
    fill_bank(0, 256, 0);
    out_ready = 1'b0;
    send(10, 1, 0, 1'b0);
    send(20, 1, 0, 1'b0);
    send(30, 1, 0, 1'b1);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk_p);
      n++;
    end while (out_valid !== 1'b1 && n < 20);
    hold = out_data;
    check("stall_front", hold, exp_q[0].d);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_p);
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_hold", out_data, hold);
    end
    @(posedge clk_p); #1;
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight: both must vanish.
    send(50, 0, 0, 1'b0);
    send(60, 0, 0, 1'b1);
    in_valid = 1'b0;
    rst_p = 1'b1;
    exp_q.delete();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 16; a++) begin
        m_bp[b][a] = 0; m_k[b][a] = 0; m_b[b][a] = 0;
      end
    @(posedge clk_p); #1;
    rst_p = 1'b0;
    @(negedge clk_p);
    check("midrst_valid", out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_p);
      check("midrst_no_stale", out_valid, 0);
    end
    @(posedge clk_p); #1;
    send(37, 0, 0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
